// File: rtl/rom_reg_loader_if.sv
// Purpose: bundles the ROM port, direct-write port, register outputs and fill status of the loader.
// Latency: none; plain wires between the loader and its neighbours.
// Backpressure: none; start/wr_en are single-cycle strobes, no ready return.
interface rom_reg_loader_if #(
    parameter int WIDTH = 32,
    parameter int SEL_W = 3
) ();
    logic             start;
    logic [SEL_W-1:0] rom_addr;
    logic [WIDTH-1:0] rom_data;
    logic             wr_en;
    logic [SEL_W-1:0] wr_sel;
    logic [WIDTH-1:0] wr_data;
    logic [WIDTH-1:0] out0, out1, out2, out3, out4, out5, out6, out7;
    logic             busy;
    logic             done;

    // Loader side
    modport slave (
        input  start, rom_data, wr_en, wr_sel, wr_data,
        output rom_addr, out0, out1, out2, out3, out4, out5, out6, out7, busy, done
    );

    // Controller / ROM / mux side
    modport master (
        output start, rom_data, wr_en, wr_sel, wr_data,
        input  rom_addr, out0, out1, out2, out3, out4, out5, out6, out7, busy, done
    );
endinterface

// File: rtl/rom_reg_loader.sv
// Purpose: 8x32 register bank write side; direct single-register writes plus ROM->register bulk fill.
// Latency: direct write visible 1 cycle after the edge; fill takes 2 cycles/word, 16 cycles to DONE.
// Backpressure: none; start while busy/done and wr_en outside IDLE are silently dropped.
module rom_reg_loader #(
    parameter int WIDTH = 32,
    parameter int SEL_W = 3
) (
    input logic            clk,
    input logic            reset_n,
    rom_reg_loader_if.slave bus
);
    localparam int NREG = 1 << SEL_W;
    localparam logic [SEL_W-1:0] LAST = SEL_W'(NREG - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state;
    logic [SEL_W-1:0] idx;
    logic [SEL_W-1:0] rom_addr_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] regs [NREG];

    // Fill sequencer and register storage; rom_addr is loaded on entry to READ so
    // the synchronous ROM returns the word while the FSM sits in WRITE.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            idx        <= '0;
            rom_addr_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    // A write and a start on the same edge both take effect;
                    // the fill later overwrites that register with ROM data.
                    if (bus.wr_en) begin
                        regs[bus.wr_sel] <= bus.wr_data;
                    end
                    if (bus.start) begin
                        state      <= READ;
                        idx        <= '0;
                        rom_addr_q <= '0;
                        busy_q     <= 1'b1;
                    end
                end
                READ: begin
                    state <= WRITE;
                end
                WRITE: begin
                    regs[idx] <= bus.rom_data;
                    if (idx == LAST) begin
                        state  <= DONE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end else begin
                        idx        <= idx + 1'b1;
                        rom_addr_q <= idx + 1'b1;
                        state      <= READ;
                    end
                end
                DONE: begin
                    done_q <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.rom_addr = rom_addr_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.out0     = regs[0];
    assign bus.out1     = regs[1];
    assign bus.out2     = regs[2];
    assign bus.out3     = regs[3];
    assign bus.out4     = regs[4];
    assign bus.out5     = regs[5];
    assign bus.out6     = regs[6];
    assign bus.out7     = regs[7];
endmodule

// File: tb/tb_rom_reg_loader.sv
// Purpose: self-checking bench for rom_reg_loader against a fill-timeline reference model.
// Latency: inputs driven on the falling edge, outputs sampled 1 time unit after the rising edge.
// Backpressure: n/a.
module tb_rom_reg_loader;
    logic clk;
    logic reset_n;

    rom_reg_loader_if #(.WIDTH(32), .SEL_W(3)) bus ();

    rom_reg_loader #(.WIDTH(32), .SEL_W(3)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous ROM: data for the address seen on an edge is valid after that edge.
    logic [31:0] rom [8];
    always @(posedge clk) bus.rom_data <= rom[bus.rom_addr];

    // Reference model: a fill is a 17-cycle timeline after the accepting edge.
    // t counts edges since acceptance; word i lands when t == 2*i+2,
    // busy covers t=0..15, done is t==16, idle again after that.
    logic [31:0] m_regs [8];
    bit          m_fill;
    int          m_t;
    logic [2:0]  m_addr;

    int n_chk  = 0;
    int n_pass = 0;
    int busy_seen;
    int done_seen;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, got, exp);
    endtask

    function automatic logic [31:0] get_out(input int k);
        case (k)
            0: return bus.out0;
            1: return bus.out1;
            2: return bus.out2;
            3: return bus.out3;
            4: return bus.out4;
            5: return bus.out5;
            6: return bus.out6;
            default: return bus.out7;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_regs[i] = '0;
        m_fill = 0;
        m_t    = 0;
        m_addr = '0;
    endtask

    task automatic model_step(input bit st, input bit we, input logic [2:0] sel, input logic [31:0] d);
        if (!m_fill) begin
            if (we) m_regs[sel] = d;
            if (st) begin
                m_fill = 1;
                m_t    = 0;
                m_addr = 3'd0;
            end
        end else if (m_t == 16) begin
            m_fill = 0;
        end else begin
            m_t++;
            if (m_t % 2 == 0) begin
                m_regs[m_t/2 - 1] = rom[m_t/2 - 1];
                if (m_t < 16) m_addr = 3'(m_t / 2);
            end
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < 8; k++) check($sformatf("out%0d", k), get_out(k), m_regs[k]);
        check("busy", 32'(bus.busy), 32'(m_fill && m_t < 16));
        check("done", 32'(bus.done), 32'(m_fill && m_t == 16));
        check("rom_addr", 32'(bus.rom_addr), 32'(m_addr));
        check("busy_done_excl", 32'(bus.busy & bus.done), 32'd0);
    endtask

    // One clock with the given inputs, followed by model update and full compare.
    task automatic cycle(input bit st, input bit we, input logic [2:0] sel, input logic [31:0] d);
        @(negedge clk);
        bus.start   = st;
        bus.wr_en   = we;
        bus.wr_sel  = sel;
        bus.wr_data = d;
        @(posedge clk);
        #1;
        model_step(st, we, sel, d);
        check_all();
        if (bus.busy) busy_seen++;
        if (bus.done) done_seen++;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 3'd0, 32'd0);
    endtask

    // Reset asserted mid-cycle; outputs must clear before the next rising edge.
    task automatic do_reset();
        @(negedge clk);
        bus.start = 1'b0;
        bus.wr_en = 1'b0;
        reset_n   = 1'b0;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n     = 1'b0;
        bus.start   = 1'b0;
        bus.wr_en   = 1'b0;
        bus.wr_sel  = '0;
        bus.wr_data = '0;
        for (int i = 0; i < 8; i++) rom[i] = 32'hA0 + 32'(i);
        model_reset();
        #2;
        check_all();
        @(negedge clk);
        reset_n = 1'b1;

        // Direct writes, then sweep the read mux select.
        for (int k = 0; k < 8; k++) cycle(1'b0, 1'b1, 3'(k), 32'(100 + k));
        for (int s = 0; s < 8; s++) check("mux_sweep", get_out(s), 32'(100 + s));

        // Plain bulk fill.
        busy_seen = 0;
        done_seen = 0;
        cycle(1'b1, 1'b0, 3'd0, 32'd0);
        idle_cycles(20);
        check("fill_busy_len", 32'(busy_seen), 32'd16);
        check("fill_done_cnt", 32'(done_seen), 32'd1);
        for (int i = 0; i < 8; i++) check("fill_data", get_out(i), 32'hA0 + 32'(i));

        // Write and restart attempts during the fill are dropped.
        do_reset();
        busy_seen = 0;
        done_seen = 0;
        cycle(1'b1, 1'b0, 3'd0, 32'd0);
        idle_cycles(2);
        cycle(1'b1, 1'b1, 3'd3, 32'hDEAD);
        idle_cycles(8);
        cycle(1'b1, 1'b1, 3'd3, 32'hDEAD);
        idle_cycles(4);
        cycle(1'b1, 1'b1, 3'd3, 32'hDEAD);
        idle_cycles(8);
        check("busy_fill_out3", bus.out3, 32'hA3);
        check("busy_fill_busy_len", 32'(busy_seen), 32'd16);
        check("busy_fill_done_cnt", 32'(done_seen), 32'd1);

        // Reset after five words: everything clears and no done ever follows.
        busy_seen = 0;
        done_seen = 0;
        cycle(1'b1, 1'b0, 3'd0, 32'd0);
        idle_cycles(10);
        check("pre_reset_out4", bus.out4, 32'hA4);
        check("pre_reset_out5", bus.out5, 32'hA5);
        do_reset();
        busy_seen = 0;
        idle_cycles(20);
        check("reset_no_done", 32'(done_seen), 32'd0);
        check("reset_no_busy", 32'(busy_seen), 32'd0);
        for (int i = 0; i < 8; i++) check("reset_clear", get_out(i), 32'd0);

        // Write and start on the same edge.
        cycle(1'b1, 1'b1, 3'd5, 32'd7);
        check("same_edge_out5_wr", bus.out5, 32'd7);
        idle_cycles(18);
        check("same_edge_out5_rom", bus.out5, 32'hA5);

        // Randomised traffic with occasional ROM changes and resets.
        for (int n = 0; n < 500; n++) begin
            if (!m_fill && $urandom_range(0, 15) == 0)
                for (int i = 0; i < 8; i++) rom[i] = $urandom;
            if ($urandom_range(0, 99) == 0) do_reset();
            else cycle($urandom_range(0, 9) == 0, $urandom_range(0, 1) == 1,
                       3'($urandom_range(0, 7)), $urandom);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1);
    end
endmodule
